// File: rtl/seq_serializer_if.sv
// Handshake and serial-stream bundle for seq_serializer.
// The word producer and the serial consumer both sit on the master side;
// the serializer itself takes the slave modport.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  ser_out,
        input  ser_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output ser_out,
        output ser_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words over valid/ready, keeps one word in a hold buffer
// while another shifts, and emits a gap-free bit stream with ser_valid and a
// word_done pulse on the last bit. The serial line idles at 0.
// Optional macro SER_LSB_FIRST_EN: when defined, words go out LSB first;
// otherwise MSB first. Handshake and timing are the same in both builds.
module seq_serializer #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_serializer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             ser_out_r;
    logic             ser_valid_r;

    logic             load_slot;
    logic             accept;
    logic [WIDTH-1:0] sh_shifted;
    logic             sh_next_bit;
    logic             hold_first;
    logic             in_first;

`ifdef SER_LSB_FIRST_EN
    // LSB-first: shift right, the bit after the current one sits at sh[1]
    assign sh_shifted  = sh >> 1;
    assign sh_next_bit = sh[1];
    assign hold_first  = hold[0];
    assign in_first    = bus.data_in[0];
`else
    // MSB-first: shift left, the bit after the current one sits at sh[WIDTH-2]
    assign sh_shifted  = sh << 1;
    assign sh_next_bit = sh[WIDTH-2];
    assign hold_first  = hold[WIDTH-1];
    assign in_first    = bus.data_in[WIDTH-1];
`endif

    // A new word may start when idle or while the last bit of a word is out
    assign load_slot = (state == IDLE) || (cnt == LAST);

    // Hold buffer empty means a word can be taken; never during reset
    assign bus.data_ready = !rst && !hold_full;
    assign accept         = bus.data_valid && bus.data_ready;

    assign bus.busy      = (state == SHIFT) || hold_full;
    assign bus.word_done = ser_valid_r && (cnt == LAST);
    assign bus.ser_out   = ser_out_r;
    assign bus.ser_valid = ser_valid_r;

    // Shifter/hold FSM: load from hold first, else bypass the input word,
    // else shift one bit; words arriving mid-shift park in the hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_full   <= 1'b0;
            sh          <= '0;
            hold        <= '0;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
        end else if (load_slot) begin
            if (hold_full) begin
                sh          <= hold;
                hold_full   <= 1'b0;
                cnt         <= '0;
                state       <= SHIFT;
                ser_valid_r <= 1'b1;
                ser_out_r   <= hold_first;
            end else if (bus.data_valid) begin
                sh          <= bus.data_in;
                cnt         <= '0;
                state       <= SHIFT;
                ser_valid_r <= 1'b1;
                ser_out_r   <= in_first;
            end else begin
                state       <= IDLE;
                ser_valid_r <= 1'b0;
                ser_out_r   <= 1'b0;
            end
        end else begin
            sh        <= sh_shifted;
            ser_out_r <= sh_next_bit;
            cnt       <= cnt + 1'b1;
            if (accept) begin
                hold      <= bus.data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer (WIDTH=8).
// The reference model keeps the bit stream as a queue of bits still to be
// shown on ser_out plus a queue of accepted words waiting to start.
// Define SER_LSB_FIRST_EN here too when building the LSB-first variant.
module tb_seq_serializer;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    bit               curq[$];
    logic [WIDTH-1:0] pendq[$];

    seq_serializer_if #(.WIDTH(WIDTH)) bus ();

    seq_serializer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Queue every bit of a starting word in transmission order
    task automatic pushWord(input logic [WIDTH-1:0] w);
`ifdef SER_LSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) curq.push_back(w[i]);
`else
        for (int i = WIDTH - 1; i >= 0; i--) curq.push_back(w[i]);
`endif
    endtask

    // Advance the model by one clock edge using the inputs held before it
    task automatic modelStep(input logic r, input logic v, input logic [WIDTH-1:0] d);
        bit acc;
        if (r) begin
            curq.delete();
            pendq.delete();
        end else begin
            acc = v && (pendq.size() == 0);
            if (curq.size() <= 1) begin
                if (curq.size() == 1) void'(curq.pop_front());
                if (pendq.size() > 0) pushWord(pendq.pop_front());
                else if (acc) pushWord(d);
            end else begin
                void'(curq.pop_front());
                if (acc) pendq.push_back(d);
            end
        end
    endtask

    // Expected {ser_out, ser_valid, word_done, busy, data_ready}
    function automatic logic [4:0] expVec();
        logic eo, ev, ewd, eb, er;
        ev  = (curq.size() > 0);
        eo  = ev ? curq[0] : 1'b0;
        ewd = (curq.size() == 1);
        eb  = ev || (pendq.size() > 0);
        er  = !rst && (pendq.size() == 0);
        return {eo, ev, ewd, eb, er};
    endfunction

    function automatic logic [4:0] obsVec();
        return {bus.ser_out, bus.ser_valid, bus.word_done, bus.busy, bus.data_ready};
    endfunction

    // Drive one cycle of inputs, let the edge pass, sample 1 ns later
    task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] d);
        rst            = r;
        bus.data_valid = v;
        bus.data_in    = d;
        @(posedge clk);
        modelStep(r, v, d);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 8'hFF);
            e = expVec();
            checks++;
            if (obsVec() !== e) begin
                failures++;
                $display("[TB] FAIL reset_model cyc%0d got=%b want=%b", k, obsVec(), e);
            end
            checks++;
            if ({bus.ser_out, bus.ser_valid, bus.data_ready} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL reset_outputs cyc%0d got=%b want=000", k,
                         {bus.ser_out, bus.ser_valid, bus.data_ready});
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checks++;
        if ({bus.data_ready, bus.busy} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_release got ready/busy=%b want=10", {bus.data_ready, bus.busy});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] order;
        logic [4:0] e;
`ifdef SER_LSB_FIRST_EN
        order = 8'b01101100;
`else
        order = 8'b00110110;
`endif
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, k == 0, (k == 0) ? 8'h36 : 8'h00);
            e = expVec();
            checks++;
            if (obsVec() !== e) begin
                failures++;
                $display("[TB] FAIL single_model bit%0d got=%b want=%b", k, obsVec(), e);
            end
            checks++;
            if ({bus.ser_out, bus.ser_valid, bus.word_done} !== {order[7-k], 1'b1, k == 7}) begin
                failures++;
                $display("[TB] FAIL single_bit bit%0d got=%b want=%b", k,
                         {bus.ser_out, bus.ser_valid, bus.word_done}, {order[7-k], 1'b1, k == 7});
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checks++;
        if ({bus.ser_out, bus.ser_valid, bus.busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL single_after got=%b want=000", {bus.ser_out, bus.ser_valid, bus.busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [2];
        logic [15:0] gotBits, gotDone, wantBits;
        logic [4:0]  e;
        int idx, n;
        bit acc, v;
        words[0] = 8'h36;
        words[1] = 8'hA5;
`ifdef SER_LSB_FIRST_EN
        wantBits = 16'h6CA5;
`else
        wantBits = 16'h36A5;
`endif
        gotBits = '0;
        gotDone = '0;
        idx = 0;
        n   = 0;
        for (int c = 0; c < 18; c++) begin
            v   = (idx < 2);
            acc = v && (pendq.size() == 0);
            applyStimulus(1'b0, v, v ? words[idx] : 8'h00);
            if (acc) idx++;
            e = expVec();
            checks++;
            if (obsVec() !== e) begin
                failures++;
                $display("[TB] FAIL b2b_model cyc%0d got=%b want=%b", c, obsVec(), e);
            end
            if (bus.ser_valid === 1'b1 && n < 16) begin
                gotBits[15-n] = bus.ser_out;
                gotDone[15-n] = bus.word_done;
                n++;
            end
        end
        checks++;
        if (n != 16 || gotBits !== wantBits) begin
            failures++;
            $display("[TB] FAIL b2b_stream got=%h (%0d bits) want=%h (16 bits)", gotBits, n, wantBits);
        end
        checks++;
        if (gotDone !== 16'h0101) begin
            failures++;
            $display("[TB] FAIL b2b_word_done got=%b want=%b", gotDone, 16'h0101);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] gotBits;
        logic [4:0] e;
        gotBits = '0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0)      applyStimulus(1'b0, 1'b1, 8'h36);
            else if (k == 8) applyStimulus(1'b0, 1'b1, 8'hC3);
            else             applyStimulus(1'b0, 1'b0, 8'h00);
            e = expVec();
            checks++;
            if (obsVec() !== e) begin
                failures++;
                $display("[TB] FAIL bypass_model cyc%0d got=%b want=%b", k, obsVec(), e);
            end
            checks++;
            if ({bus.ser_valid, bus.data_ready} !== 2'b11) begin
                failures++;
                $display("[TB] FAIL bypass_gap cyc%0d got valid/ready=%b want=11", k,
                         {bus.ser_valid, bus.data_ready});
            end
            if (k >= 8) gotBits[15-k] = bus.ser_out;
        end
        checks++;
        if (gotBits !== 8'b11000011) begin
            failures++;
            $display("[TB] FAIL bypass_bits got=%b want=11000011", gotBits);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        applyStimulus(1'b0, 1'b1, 8'h36);
        applyStimulus(1'b0, 1'b1, 8'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.busy !== 1'b1 || bus.data_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_hold got busy/ready=%b want=10", {bus.busy, bus.data_ready});
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        checks++;
        if ({bus.ser_out, bus.ser_valid, bus.busy, bus.data_ready} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_clear got=%b want=0000",
                     {bus.ser_out, bus.ser_valid, bus.busy, bus.data_ready});
        end
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            e = expVec();
            checks++;
            if (obsVec() !== e || bus.ser_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midrst_quiet cyc%0d got=%b want=%b", k, obsVec(), e);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] e;
        logic r, v;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 1) == 1);
            applyStimulus(r, v, 8'($urandom_range(0, 255)));
            e = expVec();
            checks++;
            if (obsVec() !== e) begin
                failures++;
                $display("[TB] FAIL random_model cyc%0d got=%b want=%b", c, obsVec(), e);
            end
        end
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
